// File: rtl/tlc_pkg.sv
// Shared types and lamp decode for the junction signal controller.
package tlc_pkg;

    localparam int unsigned LAMP_W  = 3;
    localparam int unsigned PHASE_W = 4;
    localparam int unsigned HEADS   = 4;

    localparam logic [LAMP_W-1:0] RED = 3'b100;
    localparam logic [LAMP_W-1:0] YEL = 3'b010;
    localparam logic [LAMP_W-1:0] GRN = 3'b001;

    typedef enum logic [PHASE_W-1:0] {
        ALL_RED  = 4'd0,
        MAIN     = 4'd1,
        M2_YEL   = 4'd2,
        TURN     = 4'd3,
        TURN_YEL = 4'd4,
        SIDE     = 4'd5,
        SIDE_YEL = 4'd6,
        PED      = 4'd7,
        EMG_YEL  = 4'd8,
        EMG_HOLD = 4'd9
    } state_t;

    typedef struct packed {
        logic [LAMP_W-1:0] m1;
        logic [LAMP_W-1:0] m2;
        logic [LAMP_W-1:0] mt;
        logic [LAMP_W-1:0] s;
    } lamps_t;

    // Emergency mask bit order is {m1, m2, mt, s}.
    function automatic lamps_t decode_lamps(state_t st, logic [HEADS-1:0] mask);
        lamps_t l;
        l = {RED, RED, RED, RED};
        case (st)
            MAIN:     begin l.m1 = GRN; l.m2 = GRN; end
            M2_YEL:   begin l.m1 = GRN; l.m2 = YEL; end
            TURN:     begin l.m1 = GRN; l.mt = GRN; end
            TURN_YEL: begin l.m1 = YEL; l.mt = YEL; end
            SIDE:     l.s = GRN;
            SIDE_YEL: l.s = YEL;
            EMG_YEL: begin
                l.m1 = mask[3] ? YEL : RED;
                l.m2 = mask[2] ? YEL : RED;
                l.mt = mask[1] ? YEL : RED;
                l.s  = mask[0] ? YEL : RED;
            end
            default: ;
        endcase
        return l;
    endfunction

    function automatic logic [HEADS-1:0] lit_heads(lamps_t l);
        return {l.m1 != RED, l.m2 != RED, l.mt != RED, l.s != RED};
    endfunction

endpackage

// File: rtl/junction_signal_controller_if.sv
// Request inputs and lamp/debug outputs of the junction signal controller.
interface junction_signal_controller_if;
    import tlc_pkg::*;

    logic               ped_req;
    logic               emergency;
    logic [LAMP_W-1:0]  M1;
    logic [LAMP_W-1:0]  M2;
    logic [LAMP_W-1:0]  MT;
    logic [LAMP_W-1:0]  S;
    logic               ped_walk;
    logic [PHASE_W-1:0] phase;

    modport master (output ped_req, emergency,
                    input  M1, M2, MT, S, ped_walk, phase);
    modport slave  (input  ped_req, emergency,
                    output M1, M2, MT, S, ped_walk, phase);

endinterface

// File: rtl/junction_signal_controller_phase_timer.sv
// Loadable down-counter that holds at zero; done flags the last cycle of a phase.
module phase_timer #(
    parameter int unsigned     CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  cnt <= RST_VAL;
        else if (load)              cnt <= load_val;
        else if (en && cnt != '0)   cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/junction_signal_controller.sv
// Four-head junction controller with pedestrian walk phase and emergency override.
module junction_signal_controller
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_MAIN   = 7,
    parameter int unsigned T_TURN   = 3,
    parameter int unsigned T_SIDE   = 3,
    parameter int unsigned T_YEL    = 2,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_PED    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    junction_signal_controller_if.slave   bus
);

    state_t             state_q, state_d, seq_next;
    logic [HEADS-1:0]   emg_mask_q, emg_mask_d, cur_mask;
    logic               ped_pending_q, ped_pending_d;
    lamps_t             lamps_q, lamps_d;
    logic               ped_walk_q, ped_walk_d;
    logic               timer_load, timer_done;
    logic [CNT_W-1:0]   timer_val;

    function automatic logic [CNT_W-1:0] load_for(state_t st);
        case (st)
            ALL_RED:                  return CNT_W'(T_ALLRED - 1);
            MAIN:                     return CNT_W'(T_MAIN - 1);
            TURN:                     return CNT_W'(T_TURN - 1);
            SIDE:                     return CNT_W'(T_SIDE - 1);
            PED:                      return CNT_W'(T_PED - 1);
            M2_YEL, TURN_YEL,
            SIDE_YEL, EMG_YEL:        return CNT_W'(T_YEL - 1);
            default:                  return '0;
        endcase
    endfunction

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_ALLRED - 1))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (1'b1),
        .done     (timer_done)
    );

    // State, emergency mask, pending walk request and registered lamp drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ALL_RED;
            emg_mask_q    <= '0;
            ped_pending_q <= 1'b0;
            lamps_q       <= {RED, RED, RED, RED};
            ped_walk_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            emg_mask_q    <= emg_mask_d;
            ped_pending_q <= ped_pending_d;
            lamps_q       <= lamps_d;
            ped_walk_q    <= ped_walk_d;
        end
    end

    // Next state: emergency outranks the timer; emergency phases never restart.
    always_comb begin
        state_d    = state_q;
        emg_mask_d = emg_mask_q;
        seq_next   = ALL_RED;
        cur_mask   = lit_heads(decode_lamps(state_q, emg_mask_q));

        case (state_q)
            MAIN:     seq_next = M2_YEL;
            M2_YEL:   seq_next = TURN;
            TURN:     seq_next = TURN_YEL;
            TURN_YEL: seq_next = SIDE;
            SIDE:     seq_next = SIDE_YEL;
            SIDE_YEL: seq_next = ped_pending_q ? PED : ALL_RED;
            default:  seq_next = ALL_RED;
        endcase

        case (state_q)
            ALL_RED: begin
                if (bus.emergency)   state_d = EMG_HOLD;
                else if (timer_done) state_d = MAIN;
            end
            MAIN, M2_YEL, TURN, TURN_YEL, SIDE, SIDE_YEL: begin
                if (bus.emergency) begin
                    state_d    = EMG_YEL;
                    emg_mask_d = cur_mask;
                end else if (timer_done) begin
                    state_d = seq_next;
                end
            end
            PED: begin
                if (bus.emergency)   state_d = EMG_HOLD;
                else if (timer_done) state_d = ALL_RED;
            end
            EMG_YEL: begin
                if (timer_done) state_d = bus.emergency ? EMG_HOLD : ALL_RED;
            end
            EMG_HOLD: begin
                if (!bus.emergency) state_d = ALL_RED;
            end
            default: state_d = ALL_RED;
        endcase
    end

    // Timer reload on every state change; a request coinciding with PED entry survives.
    always_comb begin
        timer_load    = (state_d != state_q);
        timer_val     = load_for(state_d);
        ped_pending_d = bus.ped_req |
                        (ped_pending_q & ~((state_d == PED) && (state_q != PED)));
        lamps_d       = decode_lamps(state_d, emg_mask_d);
        ped_walk_d    = (state_d == PED);
    end

    assign bus.M1       = lamps_q.m1;
    assign bus.M2       = lamps_q.m2;
    assign bus.MT       = lamps_q.mt;
    assign bus.S        = lamps_q.s;
    assign bus.ped_walk = ped_walk_q;
    assign bus.phase    = state_q;

endmodule

// File: tb/tb_junction_signal_controller.sv
// Directed sequence checks on the default controller plus a randomised sweep on a short-timing build.
module tb_junction_signal_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk = 1'b0;
    logic reset;
    logic sw_reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic [11:0] emg_exp;

    junction_signal_controller_if bus();
    junction_signal_controller_if sw_bus();

    junction_signal_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    junction_signal_controller #(
        .CNT_W  (3),
        .T_MAIN (1),
        .T_YEL  (1),
        .T_SIDE (8)
    ) sweep (
        .clk   (clk),
        .reset (sw_reset),
        .bus   (sw_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // {M1, M2, MT, S} for every phase whose lamps do not depend on history.
    function automatic logic [11:0] exp_lamps(input int ph);
        case (ph)
            1:       return {G, G, R, R};
            2:       return {G, Y, R, R};
            3:       return {G, R, G, R};
            4:       return {Y, R, Y, R};
            5:       return {R, R, R, G};
            6:       return {R, R, R, Y};
            default: return {R, R, R, R};
        endcase
    endfunction

    function automatic logic [11:0] lamps_now();
        return {bus.M1, bus.M2, bus.MT, bus.S};
    endfunction

    task automatic run_expect(input int ph, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc++;
            chk("phase", 16'(bus.phase), 16'(ph));
            chk("ped_walk", 16'(bus.ped_walk), 16'(ph == 7));
            if (ph == 8) chk("emg_lamps", 16'(lamps_now()), 16'(emg_exp));
            else         chk("lamps", 16'(lamps_now()), 16'(exp_lamps(ph)));
        end
    endtask

    task automatic main_to_side();
        run_expect(1, 7); run_expect(2, 2); run_expect(3, 3);
        run_expect(4, 2); run_expect(5, 3);
    endtask

    // Cycle lengths of the sweep build.
    function automatic int sweep_dur(input int ph);
        case (ph)
            3:       return 3;
            5:       return 8;
            7:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic sweep_safe(input logic [11:0] cur, input logic [11:0] prev);
        logic [2:0] h [4];
        logic [2:0] p [4];
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            h[k] = cur[11 - 3*k -: 3];
            p[k] = prev[11 - 3*k -: 3];
            if (!(h[k] == R || h[k] == Y || h[k] == G)) ok = 1'b0;
            if (p[k] == G && h[k] == R) ok = 1'b0;
        end
        // Index order: 0=M1, 1=M2, 2=MT, 3=S.
        if (h[3] != R && (h[0] != R || h[1] != R || h[2] != R)) ok = 1'b0;
        if (h[2] != R && h[1] != R) ok = 1'b0;
        return ok;
    endfunction

    initial begin
        int          prev_ph, cur_ph, run_len;
        logic        valid;
        logic [11:0] prev_l, cur_l;

        reset = 1'b1; sw_reset = 1'b1;
        bus.ped_req = 1'b0;    bus.emergency = 1'b0;
        sw_bus.ped_req = 1'b0; sw_bus.emergency = 1'b0;
        emg_exp = {R, R, R, R};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", 16'(bus.phase), 16'd0);
        chk("rst_lamps", 16'(lamps_now()), 16'({R, R, R, R}));
        chk("rst_walk",  16'(bus.ped_walk), 16'd0);
        reset = 1'b0;

        // Two nominal 20-cycle sequences.
        for (int k = 0; k < 2; k++) begin
            main_to_side(); run_expect(6, 2); run_expect(0, 1);
        end

        // Pedestrian request in MAIN, second request during PED.
        run_expect(1, 1);
        bus.ped_req = 1'b1; run_expect(1, 1); bus.ped_req = 1'b0;
        run_expect(1, 5); run_expect(2, 2); run_expect(3, 3);
        run_expect(4, 2); run_expect(5, 3); run_expect(6, 2);
        run_expect(7, 1);
        bus.ped_req = 1'b1; run_expect(7, 1); bus.ped_req = 1'b0;
        run_expect(7, 2); run_expect(0, 1);
        main_to_side(); run_expect(6, 2); run_expect(7, 4); run_expect(0, 1);

        // Emergency on the second TURN cycle, held, then released.
        run_expect(1, 7); run_expect(2, 2); run_expect(3, 2);
        bus.emergency = 1'b1;
        emg_exp = {Y, R, Y, R};
        run_expect(8, 2);
        run_expect(9, 5);
        bus.emergency = 1'b0;
        run_expect(0, 1);

        // One-cycle emergency pulse in SIDE: yellow then clearance, no hold.
        run_expect(1, 7); run_expect(2, 2); run_expect(3, 3);
        run_expect(4, 2); run_expect(5, 1);
        bus.emergency = 1'b1;
        emg_exp = {R, R, R, Y};
        run_expect(8, 1);
        bus.emergency = 1'b0;
        run_expect(8, 1); run_expect(0, 1); run_expect(1, 1);

        // Pending walk request, then async reset mid-SIDE clears it.
        bus.ped_req = 1'b1; run_expect(1, 1); bus.ped_req = 1'b0;
        run_expect(1, 5); run_expect(2, 2); run_expect(3, 3);
        run_expect(4, 2); run_expect(5, 1);
        #3 reset = 1'b1;
        #1;
        chk("async_phase", 16'(bus.phase), 16'd0);
        chk("async_S",     16'(bus.S), 16'(R));
        chk("async_lamps", 16'(lamps_now()), 16'({R, R, R, R}));
        #10;
        chk("async_hold", 16'(bus.phase), 16'd0);
        reset = 1'b0;
        main_to_side(); run_expect(6, 2); run_expect(0, 1);

        // Request sampled on the very edge entering PED is kept.
        main_to_side(); run_expect(6, 1);
        bus.ped_req = 1'b1; run_expect(6, 1); run_expect(7, 1); bus.ped_req = 1'b0;
        run_expect(7, 3); run_expect(0, 1);
        main_to_side(); run_expect(6, 2); run_expect(7, 4); run_expect(0, 1);
        run_expect(1, 1);

        // Randomised sweep on the short-timing build.
        sw_reset = 1'b0;
        prev_ph = 0; run_len = 1; valid = 1'b0;
        prev_l  = {R, R, R, R};
        for (int c = 0; c < 5000; c++) begin
            sw_bus.ped_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) sw_bus.emergency = ~sw_bus.emergency;
            @(posedge clk); #1;
            cyc++;
            cur_ph = int'(sw_bus.phase);
            cur_l  = {sw_bus.M1, sw_bus.M2, sw_bus.MT, sw_bus.S};
            chk("sweep_safety", 16'(sweep_safe(cur_l, prev_l)), 16'd1);
            chk("sweep_walk", 16'(sw_bus.ped_walk), 16'(cur_ph == 7));
            if (cur_ph == prev_ph) begin
                run_len++;
            end else begin
                if (valid && prev_ph != 9 && (!(cur_ph == 8 || cur_ph == 9) || prev_ph == 8))
                    chk($sformatf("sweep_dur_ph%0d", prev_ph), 16'(run_len), 16'(sweep_dur(prev_ph)));
                valid   = 1'b1;
                prev_ph = cur_ph;
                run_len = 1;
            end
            prev_l = cur_l;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/junction_signal_controller.md
Name: junction_signal_controller

Overview:
- Parametrised successor to the fixed-timing four-approach traffic light controller: M1, M2, MT (main turn) and S (side road) signal heads.
- Phase durations are set by parameters.
- Adds a latched pedestrian request with a dedicated all-red walk phase.
- Adds an emergency override that forces a safe yellow-then-all-red sequence and holds it.
- Top-level block of the junction design; outputs drive the lamp drivers directly.

Parameters:
- CNT_W, 8, phase timer width; every T_* must be ≥1 and ≤ 2^CNT_W.
- T_MAIN, 7, cycles of main straight green (M1 and M2 green).
- T_TURN, 3, cycles of M1 and MT green.
- T_SIDE, 3, cycles of S green.
- T_YEL, 2, cycles of any yellow phase, including emergency yellow.
- T_ALLRED, 1, cycles of all-red clearance.
- T_PED, 4, cycles of pedestrian walk.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ped_req  in  1  pedestrian button; a one-cycle pulse is sufficient
- emergency  in  1  level; high requests override
- M1  out  3  main approach 1 lamps {R,Y,G}, one-hot
- M2  out  3  main approach 2 lamps {R,Y,G}
- MT  out  3  main turn lamps {R,Y,G}
- S  out  3  side road lamps {R,Y,G}
- ped_walk  out  1  walk lamp
- phase  out  4  current state code, for debug and coverage

Behaviour:
- Lamp encoding: RED=3'b100, YEL=3'b010, GRN=3'b001.
- Outputs are a Moore decode of registered state; they change only on clk edges.
- Timer: on entry to a timed state it loads T_x−1 and decrements each cycle. The transition happens on the cycle the timer reads 0, so each state lasts exactly T_x cycles.
- States and lamps, with any lamp not listed = RED:
  - ALL_RED: all red; codes 0.
  - MAIN (1): M1=M2=G.
  - M2_YEL (2): M1=G, M2=Y.
  - TURN (3): M1=G, MT=G.
  - TURN_YEL (4): M1=Y, MT=Y.
  - SIDE (5): S=G.
  - SIDE_YEL (6): S=Y.
  - PED (7): all red, ped_walk=1.
  - EMG_YEL (8): yellow on every head that was G or Y on entry.
  - EMG_HOLD (9): all red.
- Normal sequence: ALL_RED → MAIN → M2_YEL → TURN → TURN_YEL → SIDE → SIDE_YEL.
  - After SIDE_YEL, go to PED if ped_pending is set, otherwise to ALL_RED.
  - After PED, go to ALL_RED.
  - After ALL_RED, go to MAIN.
- Reset (async): state=ALL_RED, timer=T_ALLRED−1, ped_pending=0, emg_mask=0. All heads RED, ped_walk=0, phase=0.
- ped_pending:
  - Set on any cycle where ped_req=1.
  - Cleared on entry to PED.
  - A request arriving during PED sets it again for the next cycle of the sequence.
  - Simultaneous set and clear: set wins.
  - Retained across emergency.
- Emergency has priority over everything, including the timer and ped.
  - emergency=1 sampled in MAIN..SIDE_YEL: next state is EMG_YEL with timer=T_YEL−1. emg_mask captures which heads were non-red.
  - emergency=1 sampled in ALL_RED or PED: next state is EMG_HOLD; ped_walk drops immediately.
  - EMG_YEL always completes its T_YEL cycles, then goes to EMG_HOLD if emergency=1, otherwise ALL_RED.
  - EMG_HOLD stays while emergency=1. When emergency=0, it goes to ALL_RED (full T_ALLRED clearance), then MAIN.
  - emergency asserted in EMG_YEL or EMG_HOLD: no restart.
- Safety invariant: no two conflicting heads are ever G or Y simultaneously. Conflicting pairs are S vs any main head, and MT vs M2. No head goes G→R without at least one Y cycle.
- Reset mid-phase returns to ALL_RED in the same instant, independent of clk.
- Nominal cycle length with default parameters and no ped request: 20 cycles (1+7+2+3+2+3+2).

Decomposition:
- Package tlc_pkg holds:
  - lamp constants RED/YEL/GRN;
  - state enumeration with the codes above;
  - a function decoding state plus emg_mask to the four lamp vectors.
- Sub-module phase_timer (CNT_W): inputs load, load_val, en; output done. Down-counter with done = (cnt==0).

Test Plan:
- Reset pulse, then run 40 cycles → phase sequence 0,1×7,2×2,3×3,4×2,5×3,6×2,0,1…; at cycle 1 after release M1=M2=001, MT=S=100.
- ped_req pulse during MAIN → after SIDE_YEL, PED for 4 cycles with ped_walk=1 and all heads 100, then ALL_RED, then MAIN; a second pulse during PED → PED occurs again in the next sequence.
- emergency raised on the 2nd TURN cycle → next 2 cycles M1=MT=010, M2=S=100; then EMG_HOLD all 100 while high; drop it → 1 ALL_RED cycle, then MAIN.
- emergency pulsed for 1 cycle in SIDE → EMG_YEL S=010 for 2 cycles → ALL_RED (not HOLD) → MAIN.
- Async reset asserted mid-SIDE between clock edges → S=100, phase=0 immediately; ped_pending is cleared.
- Parameter sweep (T_MAIN=1, T_YEL=1, CNT_W=3, T_SIDE=8), random ped/emergency for 5000 cycles → safety invariant assertion never fires; each state lasts exactly its T_x cycles.
